// File: rtl/ss_capture_pkg.sv
// Shared constants and helpers for the seven-segment scan receiver.
// Segment patterns are active-low a..g in bits 6:0.
package ss_capture_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] SEG_BLANK_ANODES = 4'hF;

  localparam logic [1:0] IDX_MINS1  = 2'd0;
  localparam logic [1:0] IDX_MINS2  = 2'd1;
  localparam logic [1:0] IDX_HOURS1 = 2'd2;
  localparam logic [1:0] IDX_HOURS2 = 2'd3;

  localparam logic [3:0] HOURS2_MAX        = 4'd2;
  localparam logic [3:0] HOURS1_MAX_AT_TOP = 4'd3;
  localparam logic [3:0] MINS2_MAX         = 4'd5;

  typedef enum logic [1:0] {
    SLOT_BLANK,
    SLOT_SINGLE,
    SLOT_ILLEGAL
  } slot_kind_e;

  // Four BCD digits indexed by IDX_*.
  typedef logic [3:0][3:0] digits_t;

  function automatic slot_kind_e classify_anodes(input logic [3:0] an_n);
    slot_kind_e kind;
    case (an_n)
      SEG_BLANK_ANODES:                     kind = SLOT_BLANK;
      4'b1110, 4'b1101, 4'b1011, 4'b0111:   kind = SLOT_SINGLE;
      default:                              kind = SLOT_ILLEGAL;
    endcase
    return kind;
  endfunction

  function automatic logic [1:0] anode_index(input logic [3:0] an_n);
    logic [1:0] idx;
    case (an_n)
      4'b1110: idx = IDX_MINS1;
      4'b1101: idx = IDX_MINS2;
      4'b1011: idx = IDX_HOURS1;
      default: idx = IDX_HOURS2;
    endcase
    return idx;
  endfunction

  function automatic logic frame_in_range(input digits_t d);
    logic bad;
    bad = (d[IDX_HOURS2] > HOURS2_MAX) ||
          ((d[IDX_HOURS2] == HOURS2_MAX) && (d[IDX_HOURS1] > HOURS1_MAX_AT_TOP)) ||
          (d[IDX_MINS2] > MINS2_MAX);
    return !bad;
  endfunction

endpackage

// File: rtl/ss_seg_decode.sv
// Combinational decode of an active-low a..g segment pattern back to BCD.
// Patterns outside the 0..9 table report valid = 0.
module ss_seg_decode
  import ss_capture_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    bcd   = '0;
    valid = 1'b1;
    case (seg_n)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ss_capture.sv
// Seven-segment scan receiver: settle filter, slot decode, frame assembly and
// 24-hour range check. Decimal-point capture is built with SS_CAPTURE_DP_EN.
module ss_capture
  import ss_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic [3:0] SegmentDrivers,
  input  logic [7:0] SevenSegment,
  output logic [3:0] hours2,
  output logic [3:0] hours1,
  output logic [3:0] mins2,
  output logic [3:0] mins1,
`ifdef SS_CAPTURE_DP_EN
  output logic [3:0] dp_out,
`endif
  output logic       frame_valid,
  output logic       frame_err
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);

  logic [3:0] prev_an;
  logic [7:0] prev_seg;
  logic [7:0] stab_cnt;
  logic       bus_same;
  logic       settle;

  logic [3:0] dec_bcd;
  logic       dec_ok;
  slot_kind_e kind;
  logic [1:0] slot_idx;
  logic       slot_accept;

  logic [3:0] seen_q, seen_d;
  digits_t    stage_q, stage_d;
  logic       load;
  logic       valid_d, err_d;

  assign bus_same = ({SegmentDrivers, SevenSegment} == {prev_an, prev_seg});
  // Fires only on the transition into saturation, so a held slot is sampled once.
  assign settle   = bus_same && (stab_cnt == SETTLE_LAST);

  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      prev_an  <= SEG_BLANK_ANODES;
      prev_seg <= '1;
      stab_cnt <= '0;
    end else begin
      prev_an  <= SegmentDrivers;
      prev_seg <= SevenSegment;
      if (!bus_same)
        stab_cnt <= '0;
      else if (stab_cnt != SETTLE_MAX)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  ss_seg_decode u_decode (
    .seg_n (SevenSegment[6:0]),
    .bcd   (dec_bcd),
    .valid (dec_ok)
  );

  assign kind        = classify_anodes(SegmentDrivers);
  assign slot_idx    = anode_index(SegmentDrivers);
  assign slot_accept = settle && (kind == SLOT_SINGLE) && dec_ok;

  always_comb begin
    seen_d  = seen_q;
    stage_d = stage_q;
    load    = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (settle) begin
      case (kind)
        SLOT_BLANK: ;
        SLOT_SINGLE: begin
          if (dec_ok) begin
            stage_d[slot_idx] = dec_bcd;
            seen_d            = seen_q | (4'b0001 << slot_idx);
            // Range check sees the digit decoded this cycle via stage_d.
            if (&seen_d) begin
              seen_d = '0;
              if (frame_in_range(stage_d)) begin
                load    = 1'b1;
                valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end else begin
            err_d  = 1'b1;
            seen_d = '0;
          end
        end
        default: begin
          err_d  = 1'b1;
          seen_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      seen_q      <= '0;
      stage_q     <= '0;
      hours2      <= '0;
      hours1      <= '0;
      mins2       <= '0;
      mins1       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      seen_q      <= seen_d;
      stage_q     <= stage_d;
      frame_valid <= valid_d;
      frame_err   <= err_d;
      if (load) begin
        hours2 <= stage_d[IDX_HOURS2];
        hours1 <= stage_d[IDX_HOURS1];
        mins2  <= stage_d[IDX_MINS2];
        mins1  <= stage_d[IDX_MINS1];
      end
    end
  end

`ifdef SS_CAPTURE_DP_EN
  logic [3:0] dp_stage_q, dp_stage_d;

  always_comb begin
    dp_stage_d = dp_stage_q;
    if (slot_accept)
      dp_stage_d[slot_idx] = ~SevenSegment[7];
  end

  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      dp_stage_q <= '0;
      dp_out     <= '0;
    end else begin
      dp_stage_q <= dp_stage_d;
      if (load)
        dp_out <= dp_stage_d;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = slot_accept;
`endif

endmodule

// File: tb/tb_ss_capture.sv
// Directed bench for ss_capture: a slot/frame-level reference model checked
// every cycle, plus literal expectations after each scenario.
module tb_ss_capture;

  localparam int unsigned S = 16;

  localparam logic [3:0] AN_H2 = 4'b0111;
  localparam logic [3:0] AN_H1 = 4'b1011;
  localparam logic [3:0] AN_M2 = 4'b1101;
  localparam logic [3:0] AN_M1 = 4'b1110;

  logic       CLK100MHZ = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] SegmentDrivers = 4'hF;
  logic [7:0] SevenSegment = 8'hFF;
  logic [3:0] hours2, hours1, mins2, mins1;
  logic       frame_valid, frame_err;
`ifdef SS_CAPTURE_DP_EN
  logic [3:0] dp_out;
`endif

  ss_capture #(.SETTLE_CYCLES(S)) dut (
    .CLK100MHZ      (CLK100MHZ),
    .Reset          (Reset),
    .SegmentDrivers (SegmentDrivers),
    .SevenSegment   (SevenSegment),
    .hours2         (hours2),
    .hours1         (hours1),
    .mins2          (mins2),
    .mins1          (mins1),
`ifdef SS_CAPTURE_DP_EN
    .dp_out         (dp_out),
`endif
    .frame_valid    (frame_valid),
    .frame_err      (frame_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int unsigned tot = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned nv = 0;
  int unsigned ne = 0;
  bit          armed = 1'b0;

  always @(posedge CLK100MHZ) cyc++;

  function automatic logic [6:0] seg7(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'h40; 1: p = 7'h79; 2: p = 7'h24; 3: p = 7'h30; 4: p = 7'h19;
      5: p = 7'h12; 6: p = 7'h02; 7: p = 7'h78; 8: p = 7'h00; 9: p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Reference model: a slot is sampled S cycles after the bus last changed
  // (or after reset); frames are judged as a clock time hh:mm.
  int unsigned mcyc = 0;
  int unsigned change_at = 0;
  logic [11:0] prev_bus = 12'hFFF;
  int          m_stage[4];
  bit   [3:0]  m_seen = '0;
  bit   [3:0]  m_dpst = '0;
  int          e_dig[4];
  bit   [3:0]  e_dp = '0;
  bit          e_valid = 1'b0;
  bit          e_err = 1'b0;

  task automatic model_slot();
    int lows = 0;
    int pos = 0;
    int digit = -1;
    int hh, mm;
    for (int i = 0; i < 4; i++)
      if (!SegmentDrivers[i]) begin lows++; pos = i; end
    if (lows == 0) return;
    if (lows != 1) begin e_err = 1'b1; m_seen = '0; return; end
    for (int d = 0; d < 10; d++)
      if (seg7(d) == SevenSegment[6:0]) digit = d;
    if (digit < 0) begin e_err = 1'b1; m_seen = '0; return; end
    m_stage[pos] = digit;
    m_dpst[pos]  = !SevenSegment[7];
    m_seen[pos]  = 1'b1;
    if (m_seen == 4'hF) begin
      m_seen = '0;
      hh = 10 * m_stage[3] + m_stage[2];
      mm = 10 * m_stage[1] + m_stage[0];
      if (hh < 24 && mm < 60) begin
        for (int i = 0; i < 4; i++) e_dig[i] = m_stage[i];
        e_dp    = m_dpst;
        e_valid = 1'b1;
      end else begin
        e_err = 1'b1;
      end
    end
  endtask

  always @(posedge CLK100MHZ) begin
    mcyc++;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (Reset) begin
      prev_bus  = 12'hFFF;
      change_at = mcyc;
      m_seen    = '0;
      m_dpst    = '0;
      e_dp      = '0;
      for (int i = 0; i < 4; i++) begin e_dig[i] = 0; m_stage[i] = 0; end
    end else begin
      if ({SegmentDrivers, SevenSegment} != prev_bus) begin
        change_at = mcyc;
        prev_bus  = {SegmentDrivers, SevenSegment};
      end
      if (mcyc - change_at == S) model_slot();
    end
  end

  always @(negedge CLK100MHZ) begin
    logic [17:0] act, exp;
    if (armed) begin
      act = {hours2, hours1, mins2, mins1, frame_valid, frame_err};
      exp = {4'(e_dig[3]), 4'(e_dig[2]), 4'(e_dig[1]), 4'(e_dig[0]), e_valid, e_err};
      tot++;
      if (act !== exp) begin
        bad++;
        $display("FAIL model_cycle%0d: got %05h expected %05h", cyc, act, exp);
      end
`ifdef SS_CAPTURE_DP_EN
      tot++;
      if (dp_out !== e_dp) begin
        bad++;
        $display("FAIL model_dp cycle%0d: got %b expected %b", cyc, dp_out, e_dp);
      end
`endif
      if (frame_valid) nv++;
      if (frame_err) ne++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slot(input logic [3:0] an, input logic [6:0] seg, input bit dp_lit,
                      input int unsigned hold);
    @(negedge CLK100MHZ);
    SegmentDrivers = an;
    SevenSegment   = {~dp_lit, seg};
    repeat (hold - 1) @(negedge CLK100MHZ);
  endtask

  task automatic scan(input int h2, input int h1, input int m2, input int m1,
                      input bit [3:0] dpm);
    slot(AN_H2, seg7(h2), dpm[3], 20);
    slot(AN_H1, seg7(h1), dpm[2], 20);
    slot(AN_M2, seg7(m2), dpm[1], 20);
    slot(AN_M1, seg7(m1), dpm[0], 20);
    repeat (3) @(negedge CLK100MHZ);
  endtask

  function automatic logic [15:0] shown();
    return {hours2, hours1, mins2, mins1};
  endfunction

  initial begin
    int unsigned v0, e0, t0, lat;
    bit got;

    repeat (3) @(negedge CLK100MHZ);
    armed = 1'b1;
    check("reset_digits", shown(), 16'h0000);
    check("reset_strobes", {frame_valid, frame_err}, 2'b00);
    Reset = 1'b0;

    v0 = nv; e0 = ne;
    scan(1, 2, 3, 4, 4'b0000);
    check("t1234_digits", shown(), 16'h1234);
    check("t1234_valid", nv - v0, 1);
    check("t1234_err", ne - e0, 0);

    v0 = nv; e0 = ne;
    scan(2, 3, 5, 9, 4'b0000);
    check("t2359_digits", shown(), 16'h2359);
    check("t2359_valid", nv - v0, 1);
    v0 = nv; e0 = ne;
    scan(2, 4, 0, 0, 4'b0000);
    check("t2400_err", ne - e0, 1);
    check("t2400_valid", nv - v0, 0);
    check("t2400_hold", shown(), 16'h2359);

    v0 = nv; e0 = ne;
    slot(AN_H2, seg7(0), 1'b0, 20);
    slot(AN_H1, seg7(9), 1'b0, 20);
    slot(AN_M2, 7'h7F, 1'b0, 20);
    scan(0, 9, 1, 5, 4'b0000);
    check("blank_digit_err", ne - e0, 1);
    check("t0915_valid", nv - v0, 1);
    check("t0915_digits", shown(), 16'h0915);

    e0 = ne; v0 = nv;
    slot(4'b0011, seg7(1), 1'b0, 20);
    repeat (2) @(negedge CLK100MHZ);
    check("two_anodes_err", ne - e0, 1);
    e0 = ne;
    slot(4'b1111, seg7(8), 1'b0, 20);
    repeat (2) @(negedge CLK100MHZ);
    check("blank_anodes_err", ne - e0, 0);
    check("blank_anodes_valid", nv - v0, 0);

    v0 = nv; e0 = ne;
    slot(AN_H2, seg7(2), 1'b0, 20);
    slot(AN_H1, seg7(1), 1'b0, 20);
    slot(AN_M2, seg7(3), 1'b0, 20);
    slot(AN_M1, seg7(9), 1'b0, 10);
    @(negedge CLK100MHZ);
    SevenSegment = {1'b1, seg7(7)};
    t0 = cyc; got = 1'b0; lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK100MHZ);
      if (frame_valid) begin got = 1'b1; lat = cyc - t0; end
    end
    check("glitch_latency", got ? lat : 32'hDEAD, 17);
    repeat (5) @(negedge CLK100MHZ);
    check("glitch_digits", shown(), 16'h2137);
    check("glitch_valid", nv - v0, 1);
    check("glitch_err", ne - e0, 0);

    slot(AN_H2, seg7(1), 1'b0, 20);
    slot(AN_H1, seg7(1), 1'b0, 20);
    slot(AN_M2, seg7(1), 1'b0, 20);
    @(negedge CLK100MHZ);
    Reset = 1'b1;
    SegmentDrivers = 4'hF;
    SevenSegment = 8'hFF;
    repeat (2) @(negedge CLK100MHZ);
    check("midreset_digits", shown(), 16'h0000);
    Reset = 1'b0;
    v0 = nv;
    repeat (20) @(negedge CLK100MHZ);
    check("midreset_no_valid", nv - v0, 0);
    scan(0, 0, 0, 1, 4'b0100);
    check("t0001_valid", nv - v0, 1);
    check("t0001_digits", shown(), 16'h0001);
`ifdef SS_CAPTURE_DP_EN
    check("t0001_dp", dp_out, 4'b0100);
`endif

    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
